// File: rtl/stop_link_pkg.sv
// Shared definitions for the stop-status toggle link.
// Holds the transmitter FSM encoding and the link-wide default constants.
package stop_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } tx_state_e;

    localparam int GAP_CYCLES_DEF = 4;
    localparam int CNT_W_DEF      = 8;
    localparam int PCNT_W_DEF     = 16;

endpackage

// File: rtl/stop_request_tx_if.sv
// Handshake bundle between trigger logic and the stop-request transmitter.
// master is the transmitter side, slave is the trigger/receiver side.
interface stop_request_tx_if
    import stop_link_pkg::*;
#(
    parameter int PCNT_W = PCNT_W_DEF
);
    logic              live_rising;
    logic              stop_req;
    logic              get;
    logic              mirror;
    logic              busy;
    logic [PCNT_W-1:0] pulse_cnt;

    modport master (
        input  live_rising,
        input  stop_req,
        output get,
        output mirror,
        output busy,
        output pulse_cnt
    );

    modport slave (
        output live_rising,
        output stop_req,
        input  get,
        input  mirror,
        input  busy,
        input  pulse_cnt
    );

endinterface

// File: rtl/stop_request_tx.sv
// Stop-request transmitter: turns a level request into rate-limited get
// pulses while mirroring the receiver's toggle flop cycle-exactly.
module stop_request_tx
    import stop_link_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PCNT_W     = PCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    stop_request_tx_if.master bus
);

    tx_state_e         state;
    tx_state_e         next_state;
    logic              get_q;
    logic              mirror_q;
    logic              busy_c;
    logic              fire_c;
    logic [CNT_W-1:0]  hold_cnt;
    logic [PCNT_W-1:0] pcnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: compare only in IDLE, never on a live-start cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (!bus.live_rising && (bus.stop_req != mirror_q)) begin
                    next_state = ST_FIRE;
                end
            end
            ST_FIRE: next_state = ST_HOLD;
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: busy level and the pulse launch strobe.
    always_comb begin
        busy_c = (state != ST_IDLE);
        fire_c = (state == ST_IDLE) && (next_state == ST_FIRE);
    end

    // Registered get pulse and hold-off counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            get_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            get_q <= fire_c;
            if (state == ST_FIRE) begin
                hold_cnt <= CNT_W'(GAP_CYCLES - 1);
            end else if (state == ST_HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CNT_W'(1);
            end
        end
    end

    // Receiver mirror; a get toggle beats a simultaneous live-start clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mirror_q <= 1'b0;
        end else if (get_q) begin
            mirror_q <= ~mirror_q;
        end else if (bus.live_rising) begin
            mirror_q <= 1'b0;
        end
    end

    // Saturating pulse counter, restarted by live-start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (bus.live_rising) begin
            pcnt_q <= get_q ? PCNT_W'(1) : '0;
        end else if (get_q && !(&pcnt_q)) begin
            pcnt_q <= pcnt_q + PCNT_W'(1);
        end
    end

    assign bus.get       = get_q;
    assign bus.mirror    = mirror_q;
    assign bus.busy      = busy_c;
    assign bus.pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_stop_request_tx.sv
// Self-checking bench for stop_request_tx: directed table, corner
// sequences and random stimulus against an edge-time reference model.
module tb_stop_request_tx;
    import stop_link_pkg::*;

    localparam int G  = GAP_CYCLES_DEF;
    localparam int PW = PCNT_W_DEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    stop_request_tx_if #(.PCNT_W(PW)) bw ();
    stop_request_tx_if #(.PCNT_W(4))  bn ();

    stop_request_tx #(
        .GAP_CYCLES(G),
        .CNT_W(CNT_W_DEF),
        .PCNT_W(PW)
    ) dut_w (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bw)
    );

    stop_request_tx #(
        .GAP_CYCLES(G),
        .CNT_W(CNT_W_DEF),
        .PCNT_W(4)
    ) dut_n (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bn)
    );

    typedef struct {
        bit lr;
        bit sr;
        bit get;
        bit mirror;
        bit busy;
        int pcnt;
    } vec_t;

    vec_t tbl[8];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: edge index bookkeeping, not a state machine.
    int e;
    int last_fire;
    int m_pcnt;
    bit m_get;
    bit m_mirror;
    bit m_busy;

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e         = 0;
        last_fire = -1000;
        m_pcnt    = 0;
        m_get     = 1'b0;
        m_mirror  = 1'b0;
        m_busy    = 1'b0;
    endtask

    task automatic model_step(input bit lr, input bit sr);
        bit fire;
        bit nm;
        int np;
        fire = (e - last_fire >= G + 2) && !lr && (sr != m_mirror);
        nm = m_get ? !m_mirror : (lr ? 1'b0 : m_mirror);
        np = lr ? int'(m_get) : m_pcnt + int'(m_get);
        m_mirror = nm;
        m_pcnt   = np;
        m_get    = fire;
        if (fire) last_fire = e;
        m_busy = (e - last_fire) <= G;
        e++;
    endtask

    task automatic check_model();
        chk("get", int'(bw.get), int'(m_get));
        chk("mirror", int'(bw.mirror), int'(m_mirror));
        chk("busy", int'(bw.busy), int'(m_busy));
        chk("pcnt16", int'(bw.pulse_cnt), sat(m_pcnt, PW));
        chk("pcnt4", int'(bn.pulse_cnt), sat(m_pcnt, 4));
        chk("get_n", int'(bn.get), int'(m_get));
    endtask

    task automatic drive(input bit lr, input bit sr);
        bw.live_rising = lr;
        bw.stop_req    = sr;
        bn.live_rising = lr;
        bn.stop_req    = sr;
    endtask

    task automatic apply(input bit lr, input bit sr);
        @(negedge clk);
        drive(lr, sr);
        model_step(lr, sr);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic run_table();
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].lr, tbl[i].sr);
            chk("tbl_get", int'(bw.get), int'(tbl[i].get));
            chk("tbl_mirror", int'(bw.mirror), int'(tbl[i].mirror));
            chk("tbl_busy", int'(bw.busy), int'(tbl[i].busy));
            chk("tbl_pcnt", int'(bw.pulse_cnt), tbl[i].pcnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int np;
        bit sr_r;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};

        drive(1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_get", int'(bw.get), 0);
        chk("rst_mirror", int'(bw.mirror), 0);
        chk("rst_busy", int'(bw.busy), 0);
        chk("rst_pcnt", int'(bw.pulse_cnt), 0);
        rst_n = 1'b1;

        run_table();

        // live_rising in IDLE with mirror 1 and stop_req 1
        apply(1'b1, 1'b1);
        chk("lri_get", int'(bw.get), 0);
        chk("lri_mirror", int'(bw.mirror), 0);
        chk("lri_pcnt", int'(bw.pulse_cnt), 0);
        apply(1'b0, 1'b1);
        chk("lri_refire", int'(bw.get), 1);
        apply(1'b0, 1'b1);
        chk("lri_mirror1", int'(bw.mirror), 1);
        chk("lri_pcnt1", int'(bw.pulse_cnt), 1);
        repeat (G + 1) apply(1'b0, 1'b1);

        // rate limit: request up, then straight back down
        apply(1'b1, 1'b0);
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < G + 8; i++) begin
            apply(1'b0, i == 0);
            if (bw.get) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        chk("rate_gap", t2 - t1, G + 2);
        chk("rate_mirror", int'(bw.mirror), 0);
        chk("rate_pcnt", int'(bw.pulse_cnt), 2);

        // live_rising coincident with get
        apply(1'b0, 1'b1);
        chk("lrf_get", int'(bw.get), 1);
        apply(1'b1, 1'b1);
        chk("lrf_mirror", int'(bw.mirror), 1);
        chk("lrf_pcnt", int'(bw.pulse_cnt), 1);
        np = 0;
        for (int i = 0; i < G + 4; i++) begin
            apply(1'b0, 1'b1);
            if (bw.get) np++;
        end
        chk("lrf_extra", np, 0);

        // saturation: 20 pulses
        apply(1'b1, 1'b0);
        for (int i = 0; i < 20 * (G + 2); i++) begin
            apply(1'b0, ((i / (G + 2)) % 2) == 0);
        end
        chk("sat_pcnt4", int'(bn.pulse_cnt), 15);
        chk("sat_pcnt16", int'(bw.pulse_cnt), 20);

        // 2-cycle glitch inside HOLD
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b0);
        apply(1'b0, 1'b0);
        np = 0;
        for (int i = 0; i < G + 4; i++) begin
            apply(1'b0, 1'b1);
            if (bw.get) np++;
        end
        chk("glitch_pulses", np, 0);

        // async reset mid-HOLD
        apply(1'b1, 1'b1);
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_get", int'(bw.get), 0);
        chk("arst_mirror", int'(bw.mirror), 0);
        chk("arst_busy", int'(bw.busy), 0);
        chk("arst_pcnt", int'(bw.pulse_cnt), 0);
        drive(1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_table();

        // random stimulus
        sr_r = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) sr_r = ~sr_r;
            apply($urandom_range(0, 19) == 0, sr_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stop_request_tx.md
# stop_request_tx

Transmitter end of the stop-status toggle link. It converts a level stop request from the trigger logic into single-cycle `get` pulses for the `stop_status` receiver. It keeps a cycle-exact mirror of the receiver's `q`, so every pulse moves the receiver toward the requested state. Pulses are rate-limited by a programmable hold-off. Sits in the top CDT trigger fabric beside the receiver, on the same `clk`.

## Interface
- `GAP_CYCLES`, default 4: hold-off cycles after each pulse before the next compare; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the hold-off counter.
- `PCNT_W`, default 16: width of the pulse counter.
- `clk`  in  1  system clock; only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `live_rising`  in  1  one-cycle live-start pulse; the same net that drives the receiver.
- `stop_req`  in  1  level; the desired receiver `q`.
- `get`  out  1  toggle pulse to the receiver; registered.
- `mirror`  out  1  model of the receiver `q`; registered.
- `busy`  out  1  high when the FSM is not in IDLE.
- `pulse_cnt`  out  PCNT_W  number of `get` pulses since the last `live_rising`; saturating.

## Operation
- **Mirror update rule:** evaluated every edge, reproducing the receiver exactly.
  - If `get` = 1: `mirror` <= ~`mirror`. When `get` and `live_rising` coincide, `get` wins, as in the receiver.
  - Else if `live_rising` = 1: `mirror` <= 0.
  - Else: hold.
- **FSM states:** IDLE, FIRE, HOLD.
  - IDLE: if `stop_req` != `mirror` and `live_rising` = 0, go to FIRE and set `get` <= 1. If `live_rising` = 1, stay in IDLE; the compare is retried next cycle against the cleared mirror.
  - FIRE: lasts one cycle. Set `get` <= 0, hold-off counter <= GAP_CYCLES-1, go to HOLD.
  - HOLD: if the counter != 0, decrement it. When it reaches 0, go to IDLE. `live_rising` does not abort HOLD.
- **Self-correction:** if `live_rising` lands on a FIRE cycle, the mirror follows the receiver's get-wins result. The next IDLE compare then issues a corrective pulse if one is needed.
- **pulse_cnt:**
  - Increments on each edge where `get` = 1; saturates at all-ones.
  - Cleared by `live_rising`.
  - If `live_rising` and `get` coincide, it loads 1.
- **Reset values (rst_n low, asynchronous):** state IDLE, `get` 0, `mirror` 0, counter 0, `pulse_cnt` 0, `busy` 0.
  - The receiver has no reset, so the system must issue `live_rising` after `rst_n` deasserts to align the two ends.
  - Reset mid-pulse drops `get` immediately.

## Timing
- **Request latency:** `stop_req` toggles before edge k → `get` is high in the cycle after edge k → receiver `q` and `mirror` flip at edge k+1.
- **Pulse width:** `get` is exactly one cycle wide. It never rises on two consecutive cycles.
- **Pulse spacing:** minimum GAP_CYCLES+2 cycles between `get` rising edges. With the default of 4, pulses can start at edges k and k+6.
- **stop_req changes during FIRE/HOLD:** not acted on until IDLE, then compared once. A toggle and back within hold-off produces no pulse.
- **busy:** high from the cycle after the IDLE→FIRE edge until HOLD exits.
- **Width rules:** hold-off counter is CNT_W bits and never underflows. `pulse_cnt` does not wrap.

## Structure
- Shared package `stop_link_pkg`:
  - FSM state encoding (IDLE, FIRE, HOLD; 2 bits).
  - Default constants GAP_CYCLES_DEF = 4 and PCNT_W_DEF = 16, also used by the receiver wrapper and the bench.
- Single module with no sub-module. The FSM, hold-off counter, mirror and pulse counter are all local registers.

## Test plan
- **Reset then set:** release `rst_n`, pulse `live_rising`, raise `stop_req` → one `get` pulse; `mirror` 1 one cycle later; `pulse_cnt` = 1; `busy` high for GAP_CYCLES+1 cycles.
- **Rate limit:** `stop_req` goes 1, then 0 one cycle after `get` → second pulse rises exactly GAP_CYCLES+2 cycles after the first; `mirror` ends at 0; `pulse_cnt` = 2.
- **live_rising on FIRE cycle:** with `mirror` = 0 and `stop_req` = 1, assert `live_rising` coincident with `get` → `mirror` = 1 (get wins); no extra pulse; a receiver model agrees every cycle.
- **live_rising in IDLE with mirror = 1 and stop_req = 1:**
  - `mirror` clears to 0 and no pulse fires in that cycle.
  - One pulse follows on the next cycle and `mirror` returns to 1.
  - `pulse_cnt` goes 0 then 1.
- **Saturation and glitch:**
  - Run PCNT_W = 4 through 20 pulses → `pulse_cnt` holds 15.
  - A 2-cycle `stop_req` glitch inside HOLD → no pulse.
- **Async reset mid-HOLD:** assert `rst_n` low off-edge → all outputs 0 immediately; after release, behaviour is as after the first reset.
